rca_pipe: RTL and testbench

- Parametrised, pipelined ripple-carry adder/subtractor; next generation of the team's 8-bit ripple-carry adder.
- WIDTH-bit operands are split into STAGES equal slices. Each pipeline stage ripples one slice and registers its carry into the next stage.
- Adds add/subtract mode, signed-overflow flag and valid/ready handshakes on input and output, so it drops into streaming datapaths at one result per cycle.

---
 rtl/rca_pipe_pkg.sv | 20 ++
 rtl/rca_slice.sv | 39 +++
 rtl/rca_pipe.sv | 133 +++++++++++++
 tb/tb_rca_pipe.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rca_pipe_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
//
// Contents:
//   OP_ADD / OP_SUB : values of the Sub mode input.
//   full_add        : one-bit full-adder cell, returns {carry_out, sum}.
package rca_pipe_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // One-bit full adder; the basic cell every slice ripples through.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    logic s;
    logic co;
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
    return {co, s};
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational CHUNK-bit ripple-carry adder slice.
//
// Ports:
//   a, b      : CHUNK-bit operand slices (b already inverted for subtract).
//   ci        : carry into bit 0 of the slice.
//   s         : CHUNK-bit sum slice.
//   co        : carry out of the slice MSB.
//   c_msb_in  : carry into the slice MSB; XOR with co gives signed overflow
//               when this is the top slice of the word.
module rca_slice
  import rca_pipe_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  always_comb begin
    logic [CHUNK:0] c;
    logic [1:0]     fa;
    c    = '0;
    s    = '0;
    fa   = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      fa       = full_add(a[i], b[i], c[i]);
      s[i]     = fa[0];
      c[i+1]   = fa[1];
    end
    co       = c[CHUNK];
    c_msb_in = c[CHUNK-1];
  end

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshakes.
//
// The WIDTH-bit word is split into STAGES slices of CHUNK bits. Rank k adds
// slice k using the carry registered by rank k-1, passes the operands along
// (upper bits still to be added) and carries the finished lower sum bits
// with it, so every rank holds one complete in-flight operation.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both high. The whole pipe moves together on adv = !out_valid || out_ready;
// in_ready equals adv, so a full pipe can retire and accept in the same
// cycle, and a stalled output freezes every rank.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset.
//   in_valid/in_ready : operand handshake.
//   A, B, Cin, Sub    : operands, carry-in, mode (0 add, 1 subtract).
//   out_valid/out_ready : result handshake.
//   S, Cout, V        : sum/difference, carry out, signed overflow.
//
// WIDTH must be a multiple of STAGES; STAGES=1 gives a registered adder.
module rca_pipe
  import rca_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int CHUNK = WIDTH / STAGES;

  logic adv;
  logic accept;

  // Pipeline ranks.
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             c_q   [STAGES];
  logic             v_q;

  // Values entering each rank.
  logic             vld_in  [STAGES];
  logic [WIDTH-1:0] a_in    [STAGES];
  logic [WIDTH-1:0] b_in    [STAGES];
  logic             c_in    [STAGES];
  logic [WIDTH-1:0] sum_nxt [STAGES];

  // Slice results.
  logic [CHUNK-1:0] s_sl  [STAGES];
  logic             co_sl [STAGES];
  logic             cm_sl [STAGES];

  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // Rank 0 takes the raw operands; subtract is A + ~B + 1, Cin ignored.
    vld_in[0] = accept;
    a_in[0]   = A;
    b_in[0]   = (Sub == OP_SUB) ? ~B : B;
    c_in[0]   = (Sub == OP_SUB) ? 1'b1 : Cin;
    for (int k = 1; k < STAGES; k++) begin
      vld_in[k] = vld_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      c_in[k]   = c_q[k-1];
    end
    // Each rank keeps the lower bits finished upstream and fills in its slice.
    sum_nxt[0] = '0;
    sum_nxt[0][CHUNK-1:0] = s_sl[0];
    for (int k = 1; k < STAGES; k++) begin
      sum_nxt[k] = sum_q[k-1];
      sum_nxt[k][k*CHUNK +: CHUNK] = s_sl[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    rca_slice #(
      .CHUNK(CHUNK)
    ) u_slice (
      .a        (a_in[k][k*CHUNK +: CHUNK]),
      .b        (b_in[k][k*CHUNK +: CHUNK]),
      .ci       (c_in[k]),
      .s        (s_sl[k]),
      .co       (co_sl[k]),
      .c_msb_in (cm_sl[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        c_q[k]   <= 1'b0;
      end
      v_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_in[k];
        a_q[k]   <= a_in[k];
        b_q[k]   <= b_in[k];
        sum_q[k] <= sum_nxt[k];
        c_q[k]   <= co_sl[k];
      end
      // Overflow comes from the word MSB, which lives in the last slice.
      v_q <= co_sl[STAGES-1] ^ cm_sl[STAGES-1];
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign S         = sum_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign V         = v_q;

endmodule

// File: tb/tb_rca_pipe.sv
// Directed testbench for rca_pipe (WIDTH=16, STAGES=4).
module tb_rca_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        Sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] S;
  logic        Cout;
  logic        V;

  int errors = 0;
  int checks = 0;

  logic [17:0] exp_q[$];  // {cout, v, sum}

  rca_pipe #(
    .WIDTH (16),
    .STAGES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .Sub      (Sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (S),
    .Cout     (Cout),
    .V        (V)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison helper
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: one op into an empty pipe, checked for latency and value.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        input logic [15:0] exp_s, input logic exp_c, input logic exp_v);
    @(negedge clk);
    in_valid = 1'b1; A = a; B = b; Cin = cin; Sub = sub;
    #1;
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; A = $urandom_range(0, 16'hffff); B = $urandom_range(0, 16'hffff);
    for (int i = 1; i < 4; i++) begin
      chk({tag, "_early_valid"}, {31'b0, out_valid}, 32'd0);
      @(negedge clk);
    end
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_s"}, {16'b0, S}, {16'b0, exp_s});
    chk({tag, "_cout"}, {31'b0, Cout}, {31'b0, exp_c});
    chk({tag, "_v"}, {31'b0, V}, {31'b0, exp_v});
  endtask

  initial begin
    logic [17:0] e;
    int sent;
    int got;

    rst = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0; out_ready = 1'b0;

    // Reset with in_valid high and out_ready low.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; A = 16'h1234; B = 16'h4321;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_s", {16'b0, S}, 32'h0);
    chk("rst_cout", {31'b0, Cout}, 32'd0);
    chk("rst_v", {31'b0, V}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'b0, out_valid}, 32'd0);
    end

    // Directed arithmetic cases.
    run_op("carry_x", 16'h00ff, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("wrap",    16'hffff, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovf_pos", 16'h7fff, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("cin_one", 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hfffe, 1'b0, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7fff, 1'b1, 1'b1);
    run_op("sub_eq",  16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Streaming: 8 ops back to back, out_ready low in cycles 5..7.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 7);
      in_valid  = (sent < 8);
      A   = 16'(sent);
      B   = 16'(sent * 16'h1111);
      Cin = 1'b0;
      Sub = 1'b0;
      #1;
      chk("strm_in_ready", {31'b0, in_ready}, {31'b0, !(c >= 5 && c <= 7)});
      chk("strm_out_valid", {31'b0, out_valid}, {31'b0, (c >= 4 && c <= 14)});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("strm_extra_result", 32'd1, 32'd0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          chk("strm_s", {16'b0, S}, {16'b0, e[15:0]});
          chk("strm_cout", {31'b0, Cout}, {31'b0, e[17]});
          chk("strm_v", {31'b0, V}, {31'b0, e[16]});
          got++;
        end else begin
          chk("strm_hold_s", {16'b0, S}, {16'b0, exp_q[0][15:0]});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, 1'b0, 16'(sent * 16'h1112)});
        sent++;
      end
    end
    in_valid = 1'b0;
    chk("strm_got", got, 32'd8);
    chk("strm_queue_empty", exp_q.size(), 32'd0);

    // Reset mid-flight: 3 ops in the pipe, then a 1-cycle reset.
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; A = 16'h0100 + 16'(i); B = 16'h0010; Cin = 1'b0; Sub = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    run_op("after_rst", 16'h0abc, 16'h0123, 1'b0, 1'b0, 16'h0bdf, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("after_rst_idle", {31'b0, out_valid}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
